// File: rtl/crypto_copro_regif_pkg.sv
// crypto_copro_pkg: shared constants for the crypto coprocessor register front-end.
//   - CTL / STAT bit positions
//   - FSM state type
//   - word-index helpers for the register map layout
package crypto_copro_pkg;

    // CTL fields
    localparam int CTL_START  = 0;
    localparam int CTL_FIRST  = 1;
    localparam int CTL_FINAL  = 2;
    localparam int CTL_IRQ_EN = 3;

    // STAT fields
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Word index of RES[0]; result bank follows the input banks.
    function automatic int res_idx(input int nb, input int nw);
        return nb * nw;
    endfunction

    function automatic int ctl_idx(input int nb, input int nw);
        return (nb + 1) * nw;
    endfunction

    function automatic int stat_idx(input int nb, input int nw);
        return ctl_idx(nb, nw) + 1;
    endfunction

endpackage

// File: rtl/crypto_copro_regif_be_reg.sv
// regif_be_reg: 32-bit register with per-byte write enables.
//   clk_i, rst_ni : clock, async active-low reset (clears to 0)
//   i_we          : write strobe
//   i_be          : byte enables, byte b covers bits [8b+7:8b]
//   i_wdata       : write data
//   o_q           : stored value
module regif_be_reg (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_we,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0;
        end else if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_q[b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/crypto_copro_regif.sv
// crypto_copro_regif: memory-mapped register front-end for a multi-operand
// crypto coprocessor.
//   device_*      : device bus port; one-cycle registered response for every req
//   cp_operands_o : all input banks, bank b word w at [(b*NumWords+w)*32 +: 32]
//   cp_ld_o       : one-cycle start pulse; cp_first_o / cp_fb_o held while BUSY
//   cp_rdy_i      : core done strobe, cp_result_i captured into RES on it
//   irq_o         : STAT.DONE & CTL.IRQ_EN
// Map (word index): IN[b][w] = b*NumWords+w, RES[w] after the inputs,
// CTL = (NumInBanks+1)*NumWords, STAT = CTL+1.
module crypto_copro_regif
    import crypto_copro_pkg::*;
#(
    parameter int AddrWidth  = 32,
    parameter int RegAddr    = 8,
    parameter int NumInBanks = 3,
    parameter int NumWords   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             device_req_i,
    input  logic [AddrWidth-1:0]             device_addr_i,
    input  logic                             device_we_i,
    input  logic [3:0]                       device_be_i,
    input  logic [31:0]                      device_wdata_i,
    output logic                             device_rvalid_o,
    output logic [31:0]                      device_rdata_o,
    output logic [NumInBanks*NumWords*32-1:0] cp_operands_o,
    output logic                             cp_ld_o,
    output logic                             cp_first_o,
    output logic                             cp_fb_o,
    input  logic                             cp_rdy_i,
    input  logic [NumWords*32-1:0]           cp_result_i,
    output logic                             irq_o
);

    localparam int IW  = RegAddr - 2;
    localparam int NIN = NumInBanks * NumWords;

    localparam logic [IW-1:0] IDX_RES  = IW'(res_idx(NumInBanks, NumWords));
    localparam logic [IW-1:0] IDX_CTL  = IW'(ctl_idx(NumInBanks, NumWords));
    localparam logic [IW-1:0] IDX_STAT = IW'(stat_idx(NumInBanks, NumWords));

    // Only FIRST/FINAL/IRQ_EN are stored; START always reads back as 0.
    localparam logic [31:0] CTL_RD_MASK = 32'h0000_000E;

    state_e                     r_state;
    logic                       r_ld;
    logic                       r_done;
    logic                       r_err;
    logic [NumWords-1:0][31:0]  r_res;
    logic                       r_rvalid;
    logic [31:0]                r_rdata;

    logic [IW-1:0]              w_idx;
    logic                       w_wr;
    logic                       w_rd;
    logic                       w_busy;
    logic [NIN-1:0]             w_in_hit;
    logic                       w_in_any;
    logic [NIN-1:0]             w_in_we;
    logic [NIN-1:0][31:0]       w_in_q;
    logic                       w_ctl_wr;
    logic                       w_stat_wr;
    logic                       w_start;
    logic                       w_ctl_chg;
    logic                       w_err_set;
    logic                       w_done_clr;
    logic                       w_err_clr;
    logic [31:0]                w_ctl_d;
    logic [31:0]                w_ctl_q;
    logic [31:0]                w_rdata;

    assign w_idx  = device_addr_i[RegAddr-1:2];
    assign w_wr   = device_req_i & device_we_i;
    assign w_rd   = device_req_i & ~device_we_i;
    assign w_busy = (r_state == ST_BUSY);

    always_comb begin
        w_in_hit = '0;
        for (int k = 0; k < NIN; k++) begin
            w_in_hit[k] = (w_idx == IW'(k));
        end
    end

    assign w_in_any  = |w_in_hit;
    // Operand banks are frozen while the core is consuming them.
    assign w_in_we   = w_in_hit & {NIN{w_wr & ~w_busy}};
    assign w_ctl_wr  = w_wr & (w_idx == IDX_CTL);
    assign w_stat_wr = w_wr & (w_idx == IDX_STAT);

    assign w_start    = w_ctl_wr & device_be_i[0] & device_wdata_i[CTL_START] & ~w_busy;
    assign w_done_clr = w_stat_wr & device_be_i[0] & device_wdata_i[STAT_DONE];
    assign w_err_clr  = w_stat_wr & device_be_i[0] & device_wdata_i[STAT_ERR];

    // A busy-time CTL write is an error if it restarts or tries to alter
    // FIRST/FINAL; rewriting them with their current values (e.g. to toggle
    // IRQ_EN alone) is harmless.
    assign w_ctl_chg = (device_wdata_i[CTL_FINAL:CTL_FIRST] != w_ctl_q[CTL_FINAL:CTL_FIRST]);
    assign w_err_set = w_busy & w_wr &
                       (w_in_any |
                        (w_ctl_wr & device_be_i[0] & (device_wdata_i[CTL_START] | w_ctl_chg)));

    // CTL next-value: IRQ_EN always writable, FIRST/FINAL held while BUSY.
    always_comb begin
        w_ctl_d             = '0;
        w_ctl_d[CTL_IRQ_EN] = device_wdata_i[CTL_IRQ_EN];
        w_ctl_d[CTL_FIRST]  = w_busy ? w_ctl_q[CTL_FIRST] : device_wdata_i[CTL_FIRST];
        w_ctl_d[CTL_FINAL]  = w_busy ? w_ctl_q[CTL_FINAL] : device_wdata_i[CTL_FINAL];
    end

    regif_be_reg u_in [NIN-1:0] (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_we    (w_in_we),
        .i_be    (device_be_i),
        .i_wdata (device_wdata_i),
        .o_q     (w_in_q)
    );

    regif_be_reg u_ctl (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_we    (w_ctl_wr),
        .i_be    (device_be_i),
        .i_wdata (w_ctl_d),
        .o_q     (w_ctl_q)
    );

    // FSM plus STAT bits. Clears are applied before sets so a same-cycle
    // set (core done, new error) wins over a W1C.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ld    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_res   <= '0;
        end else begin
            r_ld <= 1'b0;
            if (w_done_clr) r_done <= 1'b0;
            if (w_err_clr)  r_err  <= 1'b0;
            if (w_err_set)  r_err  <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_BUSY;
                        r_ld    <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (cp_rdy_i) begin
                        r_state <= ST_IDLE;
                        r_res   <= cp_result_i;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            for (int k = 0; k < NIN; k++) begin
                if (w_in_hit[k]) w_rdata = w_in_q[k];
            end
            for (int w = 0; w < NumWords; w++) begin
                if (w_idx == IDX_RES + IW'(w)) w_rdata = r_res[w];
            end
            if (w_idx == IDX_CTL) w_rdata = w_ctl_q & CTL_RD_MASK;
            if (w_idx == IDX_STAT) begin
                w_rdata[STAT_BUSY] = w_busy;
                w_rdata[STAT_DONE] = r_done;
                w_rdata[STAT_ERR]  = r_err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= device_req_i;
            r_rdata  <= w_rdata;
        end
    end

    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;
    assign cp_operands_o   = w_in_q;
    assign cp_ld_o         = r_ld;
    assign cp_first_o      = w_ctl_q[CTL_FIRST];
    assign cp_fb_o         = w_ctl_q[CTL_FINAL];
    assign irq_o           = r_done & w_ctl_q[CTL_IRQ_EN];

endmodule
